alu_issue_decode: RTL and testbench

- Registered decode/issue stage that produces the ALU control interface: op code, operand selects and immediate, decoded from one RV32I instruction.
- Sits between instruction fetch and execute. Its outputs drive the ALU op input directly, and the execute-stage operand muxes feed the ALU A/B inputs.
- Single-entry pipeline register with valid/ready handshakes on both sides, plus a flush input for branch/jump redirects.

---
 rtl/alu_issue_decode_pkg.sv | 75 +++++++
 rtl/alu_issue_decode_imm_gen.sv | 38 +++
 rtl/alu_issue_decode.sv | 147 ++++++++++++++
 tb/tb_alu_issue_decode.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_decode_pkg.sv
// Shared types and constants for the ALU issue/decode stage.
package alu_issue_decode_pkg;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned ALU_OP_WIDTH = 5;
    localparam int unsigned REG_IDX_W    = 5;
    localparam int unsigned INSTR_W      = 32;

    typedef logic [ALU_OP_WIDTH-1:0] alu_op_t;

    // ALU op codes shared with the execute stage
    localparam alu_op_t OP_ADD   = 5'd0;
    localparam alu_op_t OP_SUB   = 5'd1;
    localparam alu_op_t OP_SLL   = 5'd2;
    localparam alu_op_t OP_SLT   = 5'd3;
    localparam alu_op_t OP_SLTU  = 5'd4;
    localparam alu_op_t OP_XOR   = 5'd5;
    localparam alu_op_t OP_SRL   = 5'd6;
    localparam alu_op_t OP_SRA   = 5'd7;
    localparam alu_op_t OP_OR    = 5'd8;
    localparam alu_op_t OP_AND   = 5'd9;
    localparam alu_op_t OP_PASSB = 5'd10;
    localparam alu_op_t OP_ADD4A = 5'd11;
    localparam alu_op_t OP_EQ    = 5'd12;
    localparam alu_op_t OP_NEQ   = 5'd13;
    localparam alu_op_t OP_SGTE  = 5'd14;
    localparam alu_op_t OP_SGTEU = 5'd15;

    // RV32I major opcodes (instr[6:0])
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    // Operand select encodings
    localparam logic ASEL_RS1 = 1'b0;
    localparam logic ASEL_PC  = 1'b1;
    localparam logic BSEL_RS2 = 1'b0;
    localparam logic BSEL_IMM = 1'b1;

    // Registered decode bundle handed to execute
    typedef struct packed {
        alu_op_t                alu_op;
        logic                   a_sel;
        logic                   b_sel;
        logic [XLEN-1:0]        imm;
        logic [XLEN-1:0]        pc;
        logic [REG_IDX_W-1:0]   rs1;
        logic [REG_IDX_W-1:0]   rs2;
        logic [REG_IDX_W-1:0]   rd;
        logic                   illegal;
    } issue_bundle_t;

    // Map funct3 of OP/OP-IMM to an ALU op; alt selects SUB/SRA variants
    function automatic alu_op_t arith_op(input logic [2:0] funct3, input logic alt);
        alu_op_t op;
        case (funct3)
            3'b000:  op = alt ? OP_SUB : OP_ADD;
            3'b001:  op = OP_SLL;
            3'b010:  op = OP_SLT;
            3'b011:  op = OP_SLTU;
            3'b100:  op = OP_XOR;
            3'b101:  op = alt ? OP_SRA : OP_SRL;
            3'b110:  op = OP_OR;
            default: op = OP_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_issue_decode_imm_gen.sv
// Format-specific immediate extraction, with shift amounts zero-extended.
module alu_issue_decode_imm_gen
    import alu_issue_decode_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    output logic [XLEN-1:0]    imm_c
);

    logic [6:0] opcode;
    logic [2:0] funct3;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    // Select the immediate layout from the major opcode
    always_comb begin
        imm_c = '0;
        case (opcode)
            OPC_OPIMM: begin
                // The ALU shifts by the full B operand, so funct7 must not leak in
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    imm_c = {27'b0, instr[24:20]};
                end else begin
                    imm_c = {{20{instr[31]}}, instr[31:20]};
                end
            end
            OPC_LOAD, OPC_JALR: imm_c = {{20{instr[31]}}, instr[31:20]};
            OPC_STORE:          imm_c = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OPC_BRANCH:         imm_c = {{19{instr[31]}}, instr[31], instr[7],
                                         instr[30:25], instr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC: imm_c = {instr[31:12], 12'b0};
            OPC_JAL:            imm_c = {{11{instr[31]}}, instr[31], instr[19:12],
                                         instr[20], instr[30:21], 1'b0};
            default:            imm_c = '0;
        endcase
    end

endmodule

// File: rtl/alu_issue_decode.sv
// Decode/issue stage: RV32I instruction to ALU control bundle, single-entry register.
module alu_issue_decode
    import alu_issue_decode_pkg::*;
(
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [INSTR_W-1:0]      i_instr,
    input  logic [XLEN-1:0]         i_pc,
    input  logic                    i_flush,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [ALU_OP_WIDTH-1:0] o_alu_op,
    output logic                    o_a_sel,
    output logic                    o_b_sel,
    output logic [XLEN-1:0]         o_imm,
    output logic [XLEN-1:0]         o_pc,
    output logic [REG_IDX_W-1:0]    o_rs1,
    output logic [REG_IDX_W-1:0]    o_rs2,
    output logic [REG_IDX_W-1:0]    o_rd,
    output logic                    o_illegal
);

    logic [6:0]     opcode;
    logic [2:0]     funct3;
    logic [6:0]     funct7;
    logic [XLEN-1:0] imm_c;
    logic           load_c;
    issue_bundle_t  dec_c;
    issue_bundle_t  bundle_q;
    logic           valid_q;

    assign opcode = i_instr[6:0];
    assign funct3 = i_instr[14:12];
    assign funct7 = i_instr[31:25];

    alu_issue_decode_imm_gen u_imm_gen (
        .instr (i_instr),
        .imm_c (imm_c)
    );

    // Op code, operand selects and legality from opcode/funct fields
    always_comb begin
        dec_c         = '0;
        dec_c.alu_op  = OP_ADD;
        dec_c.a_sel   = ASEL_RS1;
        dec_c.b_sel   = BSEL_RS2;
        dec_c.illegal = 1'b0;
        dec_c.imm     = imm_c;
        dec_c.pc      = i_pc;
        dec_c.rs1     = i_instr[19:15];
        dec_c.rs2     = i_instr[24:20];
        dec_c.rd      = i_instr[11:7];

        if (i_instr[1:0] != 2'b11) begin
            dec_c.illegal = 1'b1;
        end else begin
            case (opcode)
                OPC_OP: begin
                    dec_c.alu_op  = arith_op(funct3, funct7[5]);
                    dec_c.illegal = !((funct7 == 7'b0000000) ||
                                      (funct7 == 7'b0100000 &&
                                       (funct3 == 3'b000 || funct3 == 3'b101)));
                end
                OPC_OPIMM: begin
                    dec_c.alu_op  = arith_op(funct3, (funct3 == 3'b101) && funct7[5]);
                    dec_c.b_sel   = BSEL_IMM;
                    dec_c.illegal = (funct3 == 3'b001 && funct7 != 7'b0000000) ||
                                    (funct3 == 3'b101 && funct7 != 7'b0000000 &&
                                     funct7 != 7'b0100000);
                end
                OPC_LUI: begin
                    dec_c.alu_op = OP_PASSB;
                    dec_c.b_sel  = BSEL_IMM;
                end
                OPC_AUIPC: begin
                    dec_c.alu_op = OP_ADD;
                    dec_c.a_sel  = ASEL_PC;
                    dec_c.b_sel  = BSEL_IMM;
                end
                OPC_JAL: begin
                    dec_c.alu_op = OP_ADD4A;
                    dec_c.a_sel  = ASEL_PC;
                end
                OPC_JALR: begin
                    dec_c.alu_op  = OP_ADD4A;
                    dec_c.a_sel   = ASEL_PC;
                    dec_c.illegal = (funct3 != 3'b000);
                end
                OPC_BRANCH: begin
                    case (funct3)
                        3'b000:  dec_c.alu_op = OP_EQ;
                        3'b001:  dec_c.alu_op = OP_NEQ;
                        3'b100:  dec_c.alu_op = OP_SLT;
                        3'b101:  dec_c.alu_op = OP_SGTE;
                        3'b110:  dec_c.alu_op = OP_SLTU;
                        3'b111:  dec_c.alu_op = OP_SGTEU;
                        default: dec_c.illegal = 1'b1;
                    endcase
                end
                OPC_LOAD, OPC_STORE: begin
                    dec_c.alu_op = OP_ADD;
                    dec_c.b_sel  = BSEL_IMM;
                end
                default: dec_c.illegal = 1'b1;
            endcase
        end

        // Undecodable instructions present a neutral ALU setup
        if (dec_c.illegal) begin
            dec_c.alu_op = OP_ADD;
            dec_c.a_sel  = ASEL_RS1;
            dec_c.b_sel  = BSEL_RS2;
        end
    end

    assign o_ready = ~valid_q | i_ready;
    assign load_c  = i_valid & o_ready & ~i_flush;

    // Pipeline register: flush beats load, load beats drain, otherwise hold
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
        end else if (i_flush) begin
            valid_q <= 1'b0;
        end else if (load_c) begin
            valid_q  <= 1'b1;
            bundle_q <= dec_c;
        end else if (valid_q && i_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign o_valid   = valid_q;
    assign o_alu_op  = bundle_q.alu_op;
    assign o_a_sel   = bundle_q.a_sel;
    assign o_b_sel   = bundle_q.b_sel;
    assign o_imm     = bundle_q.imm;
    assign o_pc      = bundle_q.pc;
    assign o_rs1     = bundle_q.rs1;
    assign o_rs2     = bundle_q.rs2;
    assign o_rd      = bundle_q.rd;
    assign o_illegal = bundle_q.illegal;

endmodule

// File: tb/tb_alu_issue_decode.sv
// Directed self-checking bench for alu_issue_decode.
module tb_alu_issue_decode;
    import alu_issue_decode_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        ex_ready;
    logic [4:0]  alu_op;
    logic        a_sel;
    logic        b_sel;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    alu_issue_decode dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_valid   (in_valid),
        .o_ready   (out_ready),
        .i_instr   (in_instr),
        .i_pc      (in_pc),
        .i_flush   (flush),
        .o_valid   (out_valid),
        .i_ready   (ex_ready),
        .o_alu_op  (alu_op),
        .o_a_sel   (a_sel),
        .o_b_sel   (b_sel),
        .o_imm     (imm),
        .o_pc      (pc),
        .o_rs1     (rs1),
        .o_rs2     (rs2),
        .o_rd      (rd),
        .o_illegal (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_instr = 32'h0; in_pc = 32'h0;
        flush = 1'b0; ex_ready = 1'b0;
        #2;
        checks++;
        if (out_valid !== 1'b0 || alu_op !== OP_ADD || a_sel !== 1'b0 || b_sel !== 1'b0 ||
            illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got valid=%b op=%0d a=%b b=%b ill=%b, want 0 %0d 0 0 0",
                     out_valid, alu_op, a_sel, b_sel, illegal, OP_ADD);
        end
        checks++;
        if (imm !== 32'h0 || pc !== 32'h0 || rs1 !== 5'd0 || rs2 !== 5'd0 || rd !== 5'd0) begin
            errors++;
            $display("FAIL reset_data: got imm=%h pc=%h rs1=%0d rs2=%0d rd=%0d, want all 0",
                     imm, pc, rs1, rs2, rd);
        end
        checks++;
        if (out_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b want 1", out_ready);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_sub_fields();
        ex_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h40B50533; in_pc = 32'h0000_0100;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || alu_op !== OP_SUB || a_sel !== 1'b0 || b_sel !== 1'b0 ||
            illegal !== 1'b0) begin
            errors++;
            $display("FAIL sub_ctrl: got valid=%b op=%0d a=%b b=%b ill=%b, want 1 %0d 0 0 0",
                     out_valid, alu_op, a_sel, b_sel, illegal, OP_SUB);
        end
        checks++;
        if (rs1 !== 5'd10 || rs2 !== 5'd11 || rd !== 5'd10 || pc !== 32'h0000_0100) begin
            errors++;
            $display("FAIL sub_regs: got rs1=%0d rs2=%0d rd=%0d pc=%h, want 10 11 10 00000100",
                     rs1, rs2, rd, pc);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL sub_drain: got valid=%b want 0", out_valid);
        end
    endtask

    typedef struct packed {
        logic [31:0] instr;
        logic [4:0]  op;
        logic        a;
        logic        b;
        logic [31:0] imm;
        logic        chk_imm;
        logic        ill;
    } vec_t;

    // Back-to-back issue of a directed table; one bundle per cycle
    task automatic test_decode_table();
        vec_t v[16];
        v[0]  = '{32'h40B50533, OP_SUB,   1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
        v[1]  = '{32'h40355513, OP_SRA,   1'b0, 1'b1, 32'h0000_0003, 1'b1, 1'b0};
        v[2]  = '{32'h00355513, OP_SRL,   1'b0, 1'b1, 32'h0000_0003, 1'b1, 1'b0};
        v[3]  = '{32'h00B55463, OP_SGTE,  1'b0, 1'b0, 32'h0000_0008, 1'b1, 1'b0};
        v[4]  = '{32'h12345537, OP_PASSB, 1'b0, 1'b1, 32'h1234_5000, 1'b1, 1'b0};
        v[5]  = '{32'h00158593, OP_ADD,   1'b0, 1'b1, 32'h0000_0001, 1'b1, 1'b0};
        v[6]  = '{32'hFFF50513, OP_ADD,   1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
        v[7]  = '{32'h00001517, OP_ADD,   1'b1, 1'b1, 32'h0000_1000, 1'b1, 1'b0};
        v[8]  = '{32'h008000EF, OP_ADD4A, 1'b1, 1'b0, 32'h0000_0008, 1'b1, 1'b0};
        v[9]  = '{32'hFEB52E23, OP_ADD,   1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0};
        v[10] = '{32'h00B52533, OP_SLT,   1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0};
        v[11] = '{32'h0000000B, OP_ADD,   1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1};
        v[12] = '{32'h00B52463, OP_ADD,   1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1};
        v[13] = '{32'h40151513, OP_ADD,   1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1};
        v[14] = '{32'h000510E7, OP_ADD,   1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1};
        v[15] = '{32'h00B50531, OP_ADD,   1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b1};
        ex_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_instr = v[i].instr; in_pc = 32'h1000 + 32'(i * 4);
            step();
            checks++;
            if (out_valid !== 1'b1 || alu_op !== v[i].op || a_sel !== v[i].a ||
                b_sel !== v[i].b || illegal !== v[i].ill) begin
                errors++;
                $display("FAIL decode_%h: got valid=%b op=%0d a=%b b=%b ill=%b, want 1 %0d %b %b %b",
                         v[i].instr, out_valid, alu_op, a_sel, b_sel, illegal,
                         v[i].op, v[i].a, v[i].b, v[i].ill);
            end
            if (v[i].chk_imm) begin
                checks++;
                if (imm !== v[i].imm) begin
                    errors++;
                    $display("FAIL imm_%h: got %h want %h", v[i].instr, imm, v[i].imm);
                end
            end
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL table_drain: got valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        ex_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00B50533; in_pc = 32'h200;
        step();
        in_instr = 32'h40B50533; in_pc = 32'h204;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (out_ready !== 1'b0 || out_valid !== 1'b1 || alu_op !== OP_ADD ||
                pc !== 32'h200 || rs2 !== 5'd11) begin
                errors++;
                $display("FAIL hold_%0d: got rdy=%b valid=%b op=%0d pc=%h rs2=%0d, want 0 1 %0d 00000200 11",
                         c, out_ready, out_valid, alu_op, pc, rs2, OP_ADD);
            end
            step();
        end
        ex_ready = 1'b1;
        #1;
        checks++;
        if (out_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_ready: got %b want 1", out_ready);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || alu_op !== OP_SUB || pc !== 32'h204) begin
            errors++;
            $display("FAIL release_next: got valid=%b op=%0d pc=%h, want 1 %0d 00000204",
                     out_valid, alu_op, pc, OP_SUB);
        end
        step();
    endtask

    task automatic test_flush();
        ex_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00B50533; in_pc = 32'h300;
        step();
        in_instr = 32'h40B50533; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0; ex_ready = 1'b1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_drop: got valid=%b want 0", out_valid);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_emit: got valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_async_reset();
        ex_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h12345537; in_pc = 32'h400;
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_hold: got valid=%b want 1", out_valid);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || alu_op !== OP_ADD || imm !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: got valid=%b op=%0d imm=%h, want 0 %0d 00000000",
                     out_valid, alu_op, imm, OP_ADD);
        end
        #1 rst_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_sub_fields();
        test_decode_table();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
